// File: rtl/header_adder_arbiter_pkg.sv
// Shared types and the round-robin search used by the header/message arbiter.
package header_adder_arb_pkg;

  localparam int MAX_CHANNELS = 16;

  typedef enum logic [1:0] {IDLE, HDR, MSG} arb_state_t;

  // First requester after last_idx, wrapping at n; returns last_idx when nobody requests.
  function automatic int next_rr_idx(input logic [MAX_CHANNELS-1:0] req,
                                     input int last_idx, input int n);
    int   idx;
    logic found;
    next_rr_idx = last_idx;
    found       = 1'b0;
    for (int k = 1; k <= MAX_CHANNELS; k++) begin
      idx = (last_idx + k) % n;
      if (!found && (k <= n) && req[idx[3:0]]) begin
        next_rr_idx = idx;
        found       = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/header_adder_arbiter_if.sv
// Avalon-ST style stream with ready back-pressure and byte-granular empty.
interface avalon_st_if #(parameter int DATA_WIDTH_IN_BYTES = 4);
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic                             valid;
  logic                             rdy;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_W-1:0]               empty;
  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;

  modport master (output valid, sop, eop, empty, data, input rdy);
  modport slave  (input valid, sop, eop, empty, data, output rdy);
endinterface

// File: rtl/header_adder_arbiter_rr_arbiter.sv
// Round-robin pointer: grant_idx holds the last granted channel and moves to the winner on advance.
module rr_arbiter
  import header_adder_arb_pkg::*;
#(
  parameter int  N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [MAX_CHANNELS-1:0] req_ext;
  logic [IDX_W-1:0]        winner;

  assign req_ext     = MAX_CHANNELS'(req);
  assign winner      = IDX_W'(next_rr_idx(req_ext, int'(grant_idx), N));
  assign grant_valid = |req;

  // Reset to the last channel so channel 0 wins the first arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         grant_idx <= IDX_W'(N - 1);
    else if (advance && grant_valid) grant_idx <= winner;
  end

endmodule

// File: rtl/header_adder_arbiter.sv
// Packet-granular round-robin share of one header adder: one header packet then one message packet per grant.
module header_adder_arbiter
  import header_adder_arb_pkg::*;
#(
  parameter int  DATA_WIDTH_IN_BYTES = 4,
  parameter int  NUM_CHANNELS        = 4,
  localparam int CH_IDX_W            = $clog2(NUM_CHANNELS),
  localparam int DW                  = 8 * DATA_WIDTH_IN_BYTES,
  localparam int EW                  = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  avalon_st_if.slave          header_in_st [NUM_CHANNELS],
  avalon_st_if.slave          msg_in_st    [NUM_CHANNELS],
  avalon_st_if.master         header_out_st,
  avalon_st_if.master         msg_out_st,
  output logic [CH_IDX_W-1:0] grant_idx,
  output logic                busy,
  output logic [31:0]         pkt_cnt
);

  arb_state_t state, state_nxt;

  logic [NUM_CHANNELS-1:0] h_valid, h_sop, h_eop;
  logic [NUM_CHANNELS-1:0] m_valid, m_sop, m_eop;
  logic [EW-1:0]           h_empty [NUM_CHANNELS];
  logic [EW-1:0]           m_empty [NUM_CHANNELS];
  logic [DW-1:0]           h_data  [NUM_CHANNELS];
  logic [DW-1:0]           m_data  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] req;
  logic                    grant_valid;
  logic                    hdr_last;
  logic                    msg_last;

  // Flatten the interface arrays so the datapath can be indexed by grant_idx.
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    assign h_valid[i] = header_in_st[i].valid;
    assign h_sop[i]   = header_in_st[i].sop;
    assign h_eop[i]   = header_in_st[i].eop;
    assign h_empty[i] = header_in_st[i].empty;
    assign h_data[i]  = header_in_st[i].data;
    assign m_valid[i] = msg_in_st[i].valid;
    assign m_sop[i]   = msg_in_st[i].sop;
    assign m_eop[i]   = msg_in_st[i].eop;
    assign m_empty[i] = msg_in_st[i].empty;
    assign m_data[i]  = msg_in_st[i].data;
    assign req[i]     = header_in_st[i].valid && header_in_st[i].sop;
    assign header_in_st[i].rdy = (state == HDR) && (grant_idx == CH_IDX_W'(i)) && header_out_st.rdy;
    assign msg_in_st[i].rdy    = (state == MSG) && (grant_idx == CH_IDX_W'(i)) && msg_out_st.rdy;
  end

  rr_arbiter #(.N(NUM_CHANNELS)) u_rr (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .advance     (state == IDLE),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign hdr_last = h_valid[grant_idx] && h_eop[grant_idx] && header_out_st.rdy;
  assign msg_last = m_valid[grant_idx] && m_eop[grant_idx] && msg_out_st.rdy;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_valid) state_nxt = HDR;
      HDR:     if (hdr_last)    state_nxt = MSG;
      MSG:     if (msg_last)    state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           pkt_cnt <= '0;
    else if ((state == MSG) && msg_last) pkt_cnt <= pkt_cnt + 32'd1;
  end

  // Outputs are zero outside their phase, so reset clears them without a clock edge.
  always_comb begin
    header_out_st.valid = 1'b0;
    header_out_st.sop   = 1'b0;
    header_out_st.eop   = 1'b0;
    header_out_st.empty = '0;
    header_out_st.data  = '0;
    msg_out_st.valid    = 1'b0;
    msg_out_st.sop      = 1'b0;
    msg_out_st.eop      = 1'b0;
    msg_out_st.empty    = '0;
    msg_out_st.data     = '0;
    if (state == HDR) begin
      header_out_st.valid = h_valid[grant_idx];
      header_out_st.sop   = h_sop[grant_idx];
      header_out_st.eop   = h_eop[grant_idx];
      header_out_st.empty = h_empty[grant_idx];
      header_out_st.data  = h_data[grant_idx];
    end
    if (state == MSG) begin
      msg_out_st.valid = m_valid[grant_idx];
      msg_out_st.sop   = m_sop[grant_idx];
      msg_out_st.eop   = m_eop[grant_idx];
      msg_out_st.empty = m_empty[grant_idx];
      msg_out_st.data  = m_data[grant_idx];
    end
  end

endmodule

// File: tb/tb_header_adder_arbiter.sv
// Directed bench: per-channel beat queues feed the arbiter, output beats and grant order are scored.
module tb_header_adder_arbiter;

  localparam int NCH = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } beat_t;

  typedef struct {
    int ch;
    int hlen;
    int mlen;
    int exp_grant;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0] hv = '0, hs = '0, he = '0, mv = '0, ms = '0, me = '0;
  logic [1:0]     hemp [NCH] = '{default: '0};
  logic [1:0]     memp [NCH] = '{default: '0};
  logic [31:0]    hd   [NCH] = '{default: '0};
  logic [31:0]    md   [NCH] = '{default: '0};
  logic [NCH-1:0] hr, mr;
  logic           ho_rdy = 1'b1;
  logic           mo_rdy = 1'b1;
  logic [1:0]     grant_idx;
  logic           busy;
  logic [31:0]    pkt_cnt;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) hdr_if [NCH] ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) msg_if [NCH] ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) ho_if ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) mo_if ();

  for (genvar c = 0; c < NCH; c++) begin : g_if
    assign hdr_if[c].valid = hv[c];
    assign hdr_if[c].sop   = hs[c];
    assign hdr_if[c].eop   = he[c];
    assign hdr_if[c].empty = hemp[c];
    assign hdr_if[c].data  = hd[c];
    assign hr[c]           = hdr_if[c].rdy;
    assign msg_if[c].valid = mv[c];
    assign msg_if[c].sop   = ms[c];
    assign msg_if[c].eop   = me[c];
    assign msg_if[c].empty = memp[c];
    assign msg_if[c].data  = md[c];
    assign mr[c]           = msg_if[c].rdy;
  end
  assign ho_if.rdy = ho_rdy;
  assign mo_if.rdy = mo_rdy;

  header_adder_arbiter #(.DATA_WIDTH_IN_BYTES(4), .NUM_CHANNELS(NCH)) dut (
    .clk           (clk),
    .rst           (rst),
    .header_in_st  (hdr_if),
    .msg_in_st     (msg_if),
    .header_out_st (ho_if),
    .msg_out_st    (mo_if),
    .grant_idx     (grant_idx),
    .busy          (busy),
    .pkt_cnt       (pkt_cnt)
  );

  beat_t hq [NCH][$];
  beat_t mq [NCH][$];
  beat_t exp_h [NCH][$];
  beat_t exp_m [NCH][$];
  beat_t got_h [NCH][$];
  beat_t got_m [NCH][$];
  int    glog[$];
  int    gl_rd = 0;
  int    total = 0;
  int    passed = 0;
  int    iso_err = 0;
  int    exp_pkt = 0;
  logic  prev_busy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic present();
    beat_t b;
    for (int c = 0; c < NCH; c++) begin
      b = '0;
      if (hq[c].size() > 0) b = hq[c][0];
      hv[c] = (hq[c].size() > 0);
      hs[c] = b.sop; he[c] = b.eop; hemp[c] = b.empty; hd[c] = b.data;
      b = '0;
      if (mq[c].size() > 0) b = mq[c][0];
      mv[c] = (mq[c].size() > 0);
      ms[c] = b.sop; me[c] = b.eop; memp[c] = b.empty; md[c] = b.data;
    end
  endtask

  // One clock: sample handshakes mid-cycle, retire fired beats after the edge, re-present.
  task automatic tick();
    logic [NCH-1:0] hf, mf;
    logic  hof, mof;
    beat_t hb, mb;
    int    g;
    #1;
    hf  = hv & hr;
    mf  = mv & mr;
    hof = ho_if.valid && ho_if.rdy;
    mof = mo_if.valid && mo_if.rdy;
    hb  = {ho_if.data, ho_if.sop, ho_if.eop, ho_if.empty};
    mb  = {mo_if.data, mo_if.sop, mo_if.eop, mo_if.empty};
    g   = int'(grant_idx);
    for (int c = 0; c < NCH; c++)
      if ((hr[c] || mr[c]) && (!busy || c != g)) iso_err++;
    if (hr[g] && !ho_rdy) iso_err++;
    if (mr[g] && !mo_rdy) iso_err++;
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (hf[c]) void'(hq[c].pop_front());
      if (mf[c]) void'(mq[c].pop_front());
    end
    if (hof) got_h[g].push_back(hb);
    if (mof) got_m[g].push_back(mb);
    present();
    #1;
    if (busy && !prev_busy) glog.push_back(int'(grant_idx));
    prev_busy = busy;
  endtask

  task automatic push_beat(input int ch, input bit is_msg, input logic [31:0] d,
                           input bit sop, input bit eop, input logic [1:0] emp, input bit scored = 1'b1);
    beat_t b;
    b = {d, sop, eop, emp};
    if (is_msg) begin
      mq[ch].push_back(b);
      if (scored) exp_m[ch].push_back(b);
    end else begin
      hq[ch].push_back(b);
      if (scored) exp_h[ch].push_back(b);
    end
  endtask

  task automatic push_pair(input int ch, input int hlen, input int mlen, input logic [31:0] base);
    for (int k = 0; k < hlen; k++) push_beat(ch, 1'b0, base + k, k == 0, k == hlen - 1, 2'(k));
    for (int k = 0; k < mlen; k++) push_beat(ch, 1'b1, base + 32'h100 + k, k == 0, k == mlen - 1, 2'(k + 1));
    exp_pkt++;
  endtask

  function automatic bit pending();
    for (int c = 0; c < NCH; c++) if (hq[c].size() > 0 || mq[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_done(input int budget);
    int n = 0;
    while ((busy || pending()) && n < budget) begin tick(); n++; end
    if (busy || pending()) chk("wait_done_timeout", 64'd1, 64'd0);
    tick();
  endtask

  task automatic cmp_streams(input string tag);
    for (int c = 0; c < NCH; c++) begin
      chk({tag, "_hdr_len"}, 64'(got_h[c].size()), 64'(exp_h[c].size()));
      for (int i = 0; i < got_h[c].size() && i < exp_h[c].size(); i++)
        chk({tag, "_hdr_beat"}, 64'(got_h[c][i]), 64'(exp_h[c][i]));
      chk({tag, "_msg_len"}, 64'(got_m[c].size()), 64'(exp_m[c].size()));
      for (int i = 0; i < got_m[c].size() && i < exp_m[c].size(); i++)
        chk({tag, "_msg_beat"}, 64'(got_m[c][i]), 64'(exp_m[c][i]));
      got_h[c].delete(); got_m[c].delete(); exp_h[c].delete(); exp_m[c].delete();
    end
  endtask

  task automatic expect_grant(input int g);
    if (gl_rd < glog.size()) chk("grant_order", 64'(glog[gl_rd]), 64'(g));
    else                     chk("grant_missing", 64'(glog.size()), 64'(gl_rd + 1));
    gl_rd++;
  endtask

  task automatic flush_all();
    for (int c = 0; c < NCH; c++) begin
      hq[c].delete(); mq[c].delete(); exp_h[c].delete(); exp_m[c].delete();
      got_h[c].delete(); got_m[c].delete();
    end
  endtask

  initial begin
    vec_t vecs[4];
    logic pat[4];
    int   n;
    vecs[0] = '{ch: 2, hlen: 1, mlen: 3, exp_grant: 2};
    vecs[1] = '{ch: 0, hlen: 3, mlen: 1, exp_grant: 0};
    vecs[2] = '{ch: 1, hlen: 2, mlen: 2, exp_grant: 1};
    vecs[3] = '{ch: 3, hlen: 1, mlen: 1, exp_grant: 3};
    pat     = '{1'b1, 1'b0, 1'b0, 1'b1};

    #1 rst = 1'b1;
    #2;
    chk("rst_ho_valid", 64'(ho_if.valid), 64'd0);
    chk("rst_mo_valid", 64'(mo_if.valid), 64'd0);
    chk("rst_ho_fields", 64'({ho_if.sop, ho_if.eop, ho_if.empty, ho_if.data}), 64'd0);
    chk("rst_mo_fields", 64'({mo_if.sop, mo_if.eop, mo_if.empty, mo_if.data}), 64'd0);
    chk("rst_in_rdy", 64'({hr, mr}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_grant_idx", 64'(grant_idx), 64'd3);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Simultaneous requests from reset
    for (int c = 0; c < NCH; c++) push_pair(c, 1, 1, 32'hA000_0000 + 32'(c << 12));
    wait_done(200);
    for (int c = 0; c < NCH; c++) expect_grant(c);
    chk("t2_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
    cmp_streams("t2");

    // Single channel with exact beats and arbitration latency
    push_beat(2, 1'b0, 32'h01234567, 1'b1, 1'b0, 2'd0);
    push_beat(2, 1'b0, 32'h89abcdef, 1'b0, 1'b0, 2'd0);
    push_beat(2, 1'b0, 32'h01234567, 1'b0, 1'b1, 2'd1);
    push_beat(2, 1'b1, 32'h89abcdef, 1'b1, 1'b0, 2'd0);
    push_beat(2, 1'b1, 32'h18181818, 1'b0, 1'b0, 2'd0);
    push_beat(2, 1'b1, 32'hf26a0028, 1'b0, 1'b0, 2'd0);
    push_beat(2, 1'b1, 32'h67469fa1, 1'b0, 1'b1, 2'd2);
    exp_pkt++;
    tick();
    chk("t1_req_not_yet_granted", 64'(busy), 64'd0);
    chk("t1_idle_rdy", 64'(hr[2]), 64'd0);
    tick();
    chk("t1_grant_idx", 64'(grant_idx), 64'd2);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_first_beat", 64'({ho_if.valid, ho_if.sop, ho_if.data}), {30'd0, 2'b11, 32'h01234567});
    wait_done(100);
    expect_grant(2);
    chk("t1_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
    chk("t1_busy_after", 64'(busy), 64'd0);
    cmp_streams("t1");

    // Table of single-channel transfers
    for (int i = 0; i < 4; i++) begin
      push_pair(vecs[i].ch, vecs[i].hlen, vecs[i].mlen, 32'h1000_0000 * 32'(i + 1));
      wait_done(100);
      expect_grant(vecs[i].exp_grant);
      chk("vec_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
      cmp_streams("vec");
    end

    // Fairness: ch1 keeps requesting, ch3 requests once
    push_pair(1, 2, 1, 32'hB100_0000);
    push_pair(3, 1, 2, 32'hB300_0000);
    push_pair(1, 1, 1, 32'hB110_0000);
    push_pair(1, 1, 2, 32'hB120_0000);
    wait_done(300);
    expect_grant(1); expect_grant(3); expect_grant(1); expect_grant(1);
    chk("t3_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
    cmp_streams("t3");

    // Back-pressure on ch0's message
    push_pair(0, 2, 5, 32'hC000_0000);
    n = 0;
    while (!mo_if.valid && n < 50) begin tick(); n++; end
    chk("t4_msg_started", 64'(mo_if.valid), 64'd1);
    for (int k = 0; k < 4; k++) begin
      mo_rdy = pat[k];
      #1;
      chk("t4_rdy_follow", 64'(mr[0]), 64'(pat[k]));
      chk("t4_valid_held", 64'(mo_if.valid), 64'd1);
      tick();
    end
    mo_rdy = 1'b1;
    wait_done(100);
    expect_grant(0);
    chk("t4_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
    cmp_streams("t4");

    // One-beat header goes straight to MSG
    push_pair(2, 1, 2, 32'hD200_0000);
    n = 0;
    while (!busy && n < 50) begin tick(); n++; end
    chk("t5_hdr_sop_eop", 64'({ho_if.valid, ho_if.sop, ho_if.eop}), 64'b111);
    chk("t5_msg_quiet_in_hdr", 64'(mo_if.valid), 64'd0);
    tick();
    chk("t5_msg_next", 64'({mo_if.valid, ho_if.valid, busy}), 64'b101);
    wait_done(100);
    expect_grant(2);
    cmp_streams("t5");

    // Valid without sop in IDLE is not a request
    push_beat(1, 1'b0, 32'hdeadbeef, 1'b0, 1'b0, 2'd0, 1'b0);
    repeat (6) tick();
    chk("t5_nosop_busy", 64'(busy), 64'd0);
    chk("t5_nosop_rdy", 64'(hr[1]), 64'd0);
    chk("t5_nosop_no_grant", 64'(glog.size()), 64'(gl_rd));
    hq[1].delete();
    tick(); tick();

    // Asynchronous reset in the middle of a stalled message
    mo_rdy = 1'b0;
    push_pair(1, 1, 3, 32'hE100_0000);
    n = 0;
    while (!mo_if.valid && n < 50) begin tick(); n++; end
    tick();
    expect_grant(1);
    chk("t6_in_msg", 64'({busy, mo_if.valid}), 64'b11);
    #1 rst = 1'b1;
    #1;
    chk("t6_mo_valid", 64'(mo_if.valid), 64'd0);
    chk("t6_mo_data", 64'(mo_if.data), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("t6_grant_idx", 64'(grant_idx), 64'd3);
    chk("t6_in_rdy", 64'(mr[1]), 64'd0);
    flush_all();
    exp_pkt = 0;
    tick(); tick();
    rst = 1'b0;
    mo_rdy = 1'b1;
    tick();
    gl_rd = glog.size();
    push_pair(2, 1, 1, 32'hF200_0000);
    push_pair(0, 2, 1, 32'hF000_0000);
    wait_done(200);
    expect_grant(0); expect_grant(2);
    chk("t6_pkt_cnt_after", 64'(pkt_cnt), 64'(exp_pkt));
    cmp_streams("t6");

    chk("rdy_isolation", 64'(iso_err), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
